// File: rtl/a2d_sched_pkg.sv
// Shared types and defaults for the A2D sweep scheduler.
package a2d_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        CONV     = 3'd2,
        WAIT_CNV = 3'd3,
        PID      = 3'd4,
        WAIT_PID = 3'd5
    } state_t;

    localparam int RES_W          = 12;
    localparam int DEF_SETTLE_CYC = 4096;
    localparam int DEF_TMO_CYC    = 65536;

endpackage

// File: rtl/a2d_sched_timer.sv
// Clearable up-counter with a terminal-count flag at LIMIT-1; holds at terminal count.
module sched_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic i_srst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int            CW     = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_srst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TC_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/a2d_sched.sv
// Sweeps the shared SPI A2D over the IR sensor channels and kicks one PID run per sweep.
// Optional conversion watchdog is built when SCHED_TMO_EN is defined.
module a2d_sched
    import a2d_sched_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int CH_W       = 3,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TMO_CYC    = DEF_TMO_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    output logic             strt_cnv,
    output logic [CH_W-1:0]  chnnl,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    output logic             IR_en,
    output logic             sens_wr,
    output logic [CH_W-1:0]  sens_idx,
    output logic [RES_W-1:0] sens_data,
    output logic             pid_strt,
    input  logic             pid_done,
    output logic             busy,
    output logic             err
);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t           r_state, w_state_next;
    logic [CH_W-1:0]  r_ch, w_ch_next;
    logic             r_strt_cnv, w_strt_cnv_next;
    logic [CH_W-1:0]  r_chnnl, w_chnnl_next;
    logic             r_ir_en, w_ir_en_next;
    logic             r_sens_wr, w_sens_wr_next;
    logic [CH_W-1:0]  r_sens_idx, w_sens_idx_next;
    logic [RES_W-1:0] r_sens_data, w_sens_data_next;
    logic             r_pid_strt, w_pid_strt_next;
    logic             r_busy, w_busy_next;
    logic             w_settle_done;
    logic             w_tmo;
    logic             w_err;

    sched_timer #(.LIMIT(SETTLE_CYC)) u_settle (
        .clk    (clk),
        .i_srst (rst),
        .i_clr  (r_state != SETTLE),
        .i_en   (r_state == SETTLE),
        .o_tc   (w_settle_done)
    );

`ifdef SCHED_TMO_EN
    logic r_err;
    logic w_wdog_tc;

    sched_timer #(.LIMIT(TMO_CYC)) u_wdog (
        .clk    (clk),
        .i_srst (rst),
        .i_clr  ((r_state != WAIT_CNV) || cnv_cmplt),
        .i_en   (1'b1),
        .o_tc   (w_wdog_tc)
    );

    // A completion arriving on the terminal cycle still wins over the timeout.
    assign w_tmo = (r_state == WAIT_CNV) && !cnv_cmplt && w_wdog_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end
    end

    assign w_err = r_err;
`else
    assign w_tmo = 1'b0;
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_strt_cnv  <= 1'b0;
            r_chnnl     <= '0;
            r_ir_en     <= 1'b0;
            r_sens_wr   <= 1'b0;
            r_sens_idx  <= '0;
            r_sens_data <= '0;
            r_pid_strt  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ch        <= w_ch_next;
            r_strt_cnv  <= w_strt_cnv_next;
            r_chnnl     <= w_chnnl_next;
            r_ir_en     <= w_ir_en_next;
            r_sens_wr   <= w_sens_wr_next;
            r_sens_idx  <= w_sens_idx_next;
            r_sens_data <= w_sens_data_next;
            r_pid_strt  <= w_pid_strt_next;
            r_busy      <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ch_next    = r_ch;
        unique case (r_state)
            IDLE: begin
                if (go && !w_err) w_state_next = SETTLE;
            end
            SETTLE: begin
                if (!go) begin
                    w_state_next = IDLE;
                end else if (w_settle_done) begin
                    w_state_next = CONV;
                    w_ch_next    = '0;
                end
            end
            CONV: begin
                w_state_next = WAIT_CNV;
            end
            WAIT_CNV: begin
                if (cnv_cmplt) begin
                    if (!go) begin
                        w_state_next = IDLE;
                    end else if (r_ch == LAST_CH) begin
                        w_state_next = PID;
                    end else begin
                        w_state_next = CONV;
                        w_ch_next    = r_ch + 1'b1;
                    end
                end else if (w_tmo) begin
                    w_state_next = IDLE;
                end
            end
            PID: begin
                w_state_next = WAIT_PID;
            end
            WAIT_PID: begin
                if (pid_done) begin
                    if (go) begin
                        w_state_next = CONV;
                        w_ch_next    = '0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_comb begin
        w_strt_cnv_next  = (w_state_next == CONV);
        w_chnnl_next     = (w_state_next == CONV) ? w_ch_next : r_chnnl;
        w_ir_en_next     = (w_state_next != IDLE);
        w_busy_next      = (w_state_next != IDLE);
        w_pid_strt_next  = (w_state_next == PID);
        w_sens_wr_next   = (r_state == WAIT_CNV) && cnv_cmplt;
        w_sens_idx_next  = w_sens_wr_next ? r_ch : r_sens_idx;
        w_sens_data_next = w_sens_wr_next ? res  : r_sens_data;
    end

    assign strt_cnv  = r_strt_cnv;
    assign chnnl     = r_chnnl;
    assign IR_en     = r_ir_en;
    assign sens_wr   = r_sens_wr;
    assign sens_idx  = r_sens_idx;
    assign sens_data = r_sens_data;
    assign pid_strt  = r_pid_strt;
    assign busy      = r_busy;
    assign err       = w_err;

endmodule

// File: tb/tb_a2d_sched.sv
// Scoreboard bench for a2d_sched: A2D and PID responders, expected-event queues, negedge monitor.
module tb_a2d_sched;
    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int SETTLE = 16;
    localparam int TMO    = 64;

    typedef struct packed {
        logic [CH_W-1:0] idx;
        logic [11:0]     data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            go  = 1'b1;
    logic            a2d_cmplt = 1'b0;
    logic            spur_cmplt = 1'b0;
    logic            pid_done_m = 1'b0;
    logic            spur_pid = 1'b0;
    logic            a2d_en = 1'b1;
    logic [11:0]     res = 12'hABC;
    logic            cnv_cmplt;
    logic            pid_done;
    logic            strt_cnv;
    logic [CH_W-1:0] chnnl;
    logic            IR_en;
    logic            sens_wr;
    logic [CH_W-1:0] sens_idx;
    logic [11:0]     sens_data;
    logic            pid_strt;
    logic            busy;
    logic            err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [CH_W-1:0] exp_ch_q[$];
    wr_t             exp_wr_q[$];
    int              exp_pid = 0;

    assign cnv_cmplt = a2d_cmplt | spur_cmplt;
    assign pid_done  = pid_done_m | spur_pid;

    a2d_sched #(
        .NUM_CH     (NUM_CH),
        .CH_W       (CH_W),
        .SETTLE_CYC (SETTLE),
        .TMO_CYC    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .IR_en     (IR_en),
        .sens_wr   (sens_wr),
        .sens_idx  (sens_idx),
        .sens_data (sens_data),
        .pid_strt  (pid_strt),
        .pid_done  (pid_done),
        .busy      (busy),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A2D responder: result 0x100+channel, completion 5 cycles after strt_cnv.
    initial begin
        logic [CH_W-1:0] ch;
        forever begin
            @(negedge clk);
            if (strt_cnv && a2d_en) begin
                ch = chnnl;
                repeat (5) @(posedge clk);
                #1;
                a2d_cmplt = 1'b1;
                res = 12'h100 + {9'd0, ch};
                @(posedge clk);
                #1;
                a2d_cmplt = 1'b0;
                res = 12'hABC;
            end
        end
    end

    // PID responder: pid_done 3 cycles after pid_strt.
    initial begin
        forever begin
            @(negedge clk);
            if (pid_strt) begin
                repeat (3) @(posedge clk);
                #1 pid_done_m = 1'b1;
                @(posedge clk);
                #1 pid_done_m = 1'b0;
            end
        end
    end

    // Monitor: every DUT pulse must match the head of its expectation queue.
    initial begin
        logic [CH_W-1:0] ec;
        wr_t             ew;
        forever begin
            @(negedge clk);
            if (strt_cnv) begin
                checks++;
                if (exp_ch_q.size() == 0) begin
                    errors++;
                    $display("FAIL strt_cnv_unexpected: chnnl=%0d required no conversion", chnnl);
                end else begin
                    ec = exp_ch_q.pop_front();
                    if (chnnl !== ec) begin
                        errors++;
                        $display("FAIL strt_cnv_chnnl: got %0d required %0d", chnnl, ec);
                    end else begin
                        $display("strt_cnv chnnl=%0d at cycle %0d", chnnl, cyc);
                    end
                end
            end
            if (sens_wr) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sens_wr_unexpected: idx=%0d data=0x%03h required no write", sens_idx, sens_data);
                end else begin
                    ew = exp_wr_q.pop_front();
                    if (sens_idx !== ew.idx || sens_data !== ew.data) begin
                        errors++;
                        $display("FAIL sens_wr: got idx=%0d data=0x%03h required idx=%0d data=0x%03h",
                                 sens_idx, sens_data, ew.idx, ew.data);
                    end else begin
                        $display("sens_wr idx=%0d data=0x%03h at cycle %0d", sens_idx, sens_data, cyc);
                    end
                end
            end
            if (pid_strt) begin
                checks++;
                if (exp_pid == 0) begin
                    errors++;
                    $display("FAIL pid_strt_unexpected: got pulse required none");
                end else begin
                    exp_pid--;
                    $display("pid_strt at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("check %s = 0x%0h", name, act);
        end
    endtask

    // which: 0 strt_cnv, 1 sens_wr, 2 pid_strt, 3 pid_done, 4 IR_en, 5 err
    task automatic wait_for(input string name, input int which, input int lim, output int at);
        int   n   = 0;
        logic hit = 1'b0;
        while (!hit && n < lim) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = strt_cnv;
                1:       hit = sens_wr;
                2:       hit = pid_strt;
                3:       hit = pid_done;
                4:       hit = IR_en;
                default: hit = err;
            endcase
        end
        at = cyc;
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, required event", name, lim);
        end
    endtask

    task automatic push_sweep(input int first, input int last, input int with_pid);
        wr_t w;
        for (int i = first; i <= last; i++) begin
            exp_ch_q.push_back(CH_W'(i));
            w.idx  = CH_W'(i);
            w.data = 12'h100 + 12'(i);
            exp_wr_q.push_back(w);
        end
        exp_pid += with_pid;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ir_at, at, pd_at, s_at;

        // 1: reset held with go=1
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", {8'd0, strt_cnv, chnnl, IR_en, sens_wr, sens_idx, sens_data,
                                  pid_strt, busy, err}, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("IR_en_before_first_edge", {31'd0, IR_en}, 32'd0);
        @(negedge clk);
        chk("IR_en_after_reset", {31'd0, IR_en}, 32'd1);
        chk("busy_after_reset", {31'd0, busy}, 32'd1);
        ir_at = cyc;

        // 2: full sweep after settle
        push_sweep(0, NUM_CH - 1, 1);
        wait_for("first_strt", 0, 40, at);
        chk("settle_gap", at - ir_at, 32'(SETTLE));
        wait_for("pid_strt_sweep1", 2, 200, at);

        // 3: pid_done with go=1 restarts immediately, then stop with go=0
        push_sweep(0, NUM_CH - 1, 1);
        wait_for("pid_done_sweep1", 3, 20, pd_at);
        wait_for("strt_after_pid", 0, 10, at);
        chk("no_resettle_gap", at - pd_at, 32'd1);
        wait_for("pid_strt_sweep2", 2, 200, at);
        go = 1'b0;
        wait_for("pid_done_sweep2", 3, 20, pd_at);
        @(negedge clk);
        chk("IR_en_after_stop", {31'd0, IR_en}, 32'd0);
        chk("busy_after_stop", {31'd0, busy}, 32'd0);

        // 4: go drops mid-sweep on channel 3
        @(negedge clk);
        go = 1'b1;
        push_sweep(0, 3, 0);
        for (int i = 0; i < 4; i++) wait_for("strt_partial", 0, 60, at);
        @(negedge clk);
        @(negedge clk);
        go = 1'b0;
        wait_for("wr_ch3", 1, 20, at);
        chk("busy_after_drop", {31'd0, busy}, 32'd0);
        chk("IR_en_after_drop", {31'd0, IR_en}, 32'd0);
        repeat (30) @(negedge clk);

        // 5: spurious cnv_cmplt in SETTLE, spurious pid_done in WAIT_CNV
        go = 1'b1;
        push_sweep(0, 0, 0);
        wait_for("IR_en_rise", 4, 5, ir_at);
        repeat (2) @(negedge clk);
        spur_cmplt = 1'b1;
        @(negedge clk);
        spur_cmplt = 1'b0;
        wait_for("strt_after_spur", 0, 40, at);
        chk("settle_gap_spur", at - ir_at, 32'(SETTLE));
        @(negedge clk);
        spur_pid = 1'b1;
        @(negedge clk);
        spur_pid = 1'b0;
        go = 1'b0;
        chk("busy_in_wait_cnv", {31'd0, busy}, 32'd1);
        wait_for("wr_after_spur", 1, 20, at);
        chk("busy_after_spur_stop", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);

        // reset in the middle of a conversion
        go = 1'b1;
        exp_ch_q.push_back('0);
        wait_for("strt_before_rst", 0, 40, at);
        @(negedge clk);
        go  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_outputs", {8'd0, strt_cnv, chnnl, IR_en, sens_wr, sens_idx, sens_data,
                                pid_strt, busy, err}, 32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("idle_after_rst", {30'd0, busy, IR_en}, 32'd0);

`ifdef SCHED_TMO_EN
        // 6: A2D never answers
        a2d_en = 1'b0;
        go = 1'b1;
        exp_ch_q.push_back('0);
        wait_for("strt_tmo", 0, 40, s_at);
        wait_for("err_rise", 5, 100, at);
        chk("tmo_latency", at - s_at, 32'(TMO + 1));
        chk("IR_en_after_tmo", {31'd0, IR_en}, 32'd0);
        repeat (20) @(negedge clk);
        chk("go_ignored_err", {30'd0, busy, err}, 32'd1);
        go  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", {31'd0, err}, 32'd0);
        a2d_en = 1'b1;
`else
        s_at = 0;
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        checks++;
        if (exp_ch_q.size() != 0 || exp_wr_q.size() != 0 || exp_pid != 0) begin
            errors++;
            $display("FAIL drain: got pending strt=%0d wr=%0d pid=%0d required 0",
                     exp_ch_q.size(), exp_wr_q.size(), exp_pid);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a2d_sched.md
Name: a2d_sched

Overview:
- Sequencer that shares the single SPI A2D converter among the NUM_CH IR line sensors while the follower is moving.
- Driven by the command controller's go output.
- Powers the IR emitters and waits for them to settle, then converts each channel in order and writes every result to the sensor register file.
- Launches one PID computation per full sweep and handshakes its completion.

Parameters:
NUM_CH, 8, number of sensor channels swept per cycle (2..8)
CH_W, 3, channel index width (clog2 of 8)
SETTLE_CYC, 4096, clocks of emitter settle time after IR_en rises (>=2)
TMO_CYC, 65536, watchdog limit in clocks for a conversion (used only with SCHED_TMO_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
go  in  1  motion enabled (from cmd_cntrl)
strt_cnv  out  1  one-cycle pulse that starts an A2D conversion
chnnl  out  CH_W  A2D channel select; stable from strt_cnv until cnv_cmplt
cnv_cmplt  in  1  one-cycle pulse; res is valid this cycle
res  in  12  conversion result
IR_en  out  1  IR emitter enable
sens_wr  out  1  one-cycle write strobe to the sensor register file
sens_idx  out  CH_W  write index
sens_data  out  12  write data
pid_strt  out  1  one-cycle pulse that starts the PID calculation
pid_done  in  1  one-cycle pulse; PID finished
busy  out  1  high in every state except IDLE
err  out  1  sticky conversion timeout flag

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All outputs are registered. On reset every output is 0, the channel counter is 0, the settle counter is 0 and the state is IDLE.
- IDLE:
  - IR_en=0, busy=0.
  - go=1 → IR_en<=1, settle counter cleared, go to SETTLE.
- SETTLE:
  - The counter increments each cycle.
  - If go=0 → IR_en<=0, go to IDLE (no conversion is issued).
  - When the count reaches SETTLE_CYC-1 → ch<=0, go to CONV.
- CONV:
  - Lasts exactly one cycle and cannot be aborted.
  - strt_cnv<=1 and chnnl<=ch, then go to WAIT_CNV.
- WAIT_CNV: on cnv_cmplt, in the next cycle:
  - sens_wr=1, sens_idx=ch, sens_data=res as captured in the cnv_cmplt cycle.
  - Then:
    - If go=0 → IR_en<=0, go to IDLE.
    - Else if ch==NUM_CH-1 → go to PID.
    - Else → ch<=ch+1, go to CONV.
- PID: pid_strt<=1 for one cycle, go to WAIT_PID.
- WAIT_PID: on pid_done:
  - If go=1 → ch<=0, go to CONV. Emitters stay on, so there is no re-settle.
  - Else → IR_en<=0, go to IDLE.
- Dropping go never truncates an SPI transaction or a PID run. Only the point at which the block stops is affected.
- Timing: strt_cnv pulses are at least 2 cycles apart. Latency from cnv_cmplt to sens_wr is exactly 1 cycle.
- Unexpected pulses:
  - cnv_cmplt outside WAIT_CNV is ignored.
  - pid_done outside WAIT_PID is ignored.
- Channel counter: counts 0..NUM_CH-1 only and never wraps through unused codes.
- rst mid-sweep: everything returns to reset values on the next edge, including IR_en=0. No pending write is emitted.

Optional Feature:
SCHED_TMO_EN
- Defined:
  - A watchdog counts cycles spent in WAIT_CNV and clears on each cnv_cmplt.
  - When it reaches TMO_CYC-1: err<=1 (sticky until rst), IR_en<=0, go to IDLE, and no sens_wr is issued.
  - While err=1, go is ignored.
- Undefined: no watchdog logic is built, err is tied 0, and WAIT_CNV waits indefinitely.

Decomposition:
- Package a2d_sched_pkg:
  - State enum {IDLE, SETTLE, CONV, WAIT_CNV, PID, WAIT_PID}.
  - Result width constant (12).
  - Default SETTLE_CYC and TMO_CYC.
- One sub-module, sched_timer: a loadable up-counter with a terminal-count compare. It is instanced for the settle count and, under the macro, for the watchdog.

Test Plan:
1. rst=1 for 2 cycles with go=1 → all outputs 0, state IDLE; after rst=0, IR_en rises 1 cycle later.
2. go=1, SETTLE_CYC=16, A2D model replies res=0x100+ch 5 cycles after each strt_cnv → first strt_cnv 16 cycles after IR_en; 8 writes sens_idx 0..7 with data 0x100..0x107; one pid_strt.
3. pid_done returned with go=1 → next strt_cnv has chnnl=0 with no settle gap; with go=0 → IR_en=0 and busy=0 one cycle later.
4. go drops 2 cycles after strt_cnv for ch=3 → conversion completes, sens_wr idx=3, then IDLE; no further strt_cnv and no pid_strt.
5. Spurious cnv_cmplt in SETTLE plus a pid_done in WAIT_CNV → no sens_wr and no state change.
6. (SCHED_TMO_EN, TMO_CYC=64) A2D never answers → err=1 after 64 cycles in WAIT_CNV; IR_en=0; go ignored until rst.
